// File: rtl/soc_mem_arbiter_pkg.sv
// soc_pkg: arbiter state type and clog2-based width helpers shared by the arbiter slice
//   arb_state_t  IDLE / ACCESS / RESP
//   idx_w(n)     bits needed to index n masters (at least 1)
//   cnt_w(t)     bits needed to hold a count up to t (at least 1)
package soc_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/soc_mem_arbiter_if.sv
// soc_mem_arbiter_if: request/response bus of N masters plus the shared slave memory bus
//   m_req/m_rw/m_addr/m_wdata        master requests (addr/wdata packed per master)
//   m_resp_valid/m_resp_err/m_rdata  per-master completion pulse, error flag, shared read data
//   mem_ce/mem_rw/mem_addr/mem_wdata slave access, held for the whole access
//   mem_valid/mem_rdata              slave completion and read data
//   busy                             arbiter not idle
//   modport slave: the arbiter's view; modport master: the requesters' and memory's view
interface soc_mem_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
);
    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS-1:0]        m_rw;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_resp_valid;
    logic [N_MASTERS-1:0]        m_resp_err;
    logic [DATA_W-1:0]           m_rdata;
    logic                        mem_ce;
    logic                        mem_rw;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic                        mem_valid;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        busy;

    modport slave (
        input  m_req, m_rw, m_addr, m_wdata, mem_valid, mem_rdata,
        output m_resp_valid, m_resp_err, m_rdata, mem_ce, mem_rw, mem_addr, mem_wdata, busy
    );

    modport master (
        output m_req, m_rw, m_addr, m_wdata, mem_valid, mem_rdata,
        input  m_resp_valid, m_resp_err, m_rdata, mem_ce, mem_rw, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/soc_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set req bit at or after ptr
//   req           request vector
//   ptr           search start index (state kept by the caller)
//   grant_onehot  one-hot grant, zero when no request
//   grant_idx     index of the granted request
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);
    // scanning offsets from far to near lets the nearest set bit overwrite the rest
    always_comb begin
        int j;
        j = 0;
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= N) ? j - N : j;
            grant_idx = req[j] ? IW'(j) : grant_idx;
        end
        grant_onehot = (|req) ? N'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: round-robin N-master to 1-slave memory arbiter with response timeout
//   clk  clock, all state on posedge
//   rst  asynchronous active-high reset
//   bus  soc_mem_arbiter_if.slave: master requests/responses and the slave memory bus
//   TIMEOUT = 0 disables the timeout
module soc_mem_arbiter
    import soc_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int TIMEOUT   = 255
) (
    input logic              clk,
    input logic              rst,
    soc_mem_arbiter_if.slave bus
);
    localparam int IW = idx_w(N_MASTERS);
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW:0] TO = (CW + 1)'(TIMEOUT);

    arb_state_t           state;
    logic [IW-1:0]        rr_ptr, grant, gidx;
    logic [N_MASTERS-1:0] grant_oh, gonehot;
    logic [CW-1:0]        cnt;

    rr_arbiter #(.N(N_MASTERS), .IW(IW)) u_rr (
        .req          (bus.m_req),
        .ptr          (rr_ptr),
        .grant_onehot (gonehot),
        .grant_idx    (gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            grant            <= '0;
            grant_oh         <= '0;
            cnt              <= '0;
            bus.m_resp_valid <= '0;
            bus.m_resp_err   <= '0;
            bus.m_rdata      <= '0;
            bus.mem_ce       <= 1'b0;
            bus.mem_rw       <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wdata    <= '0;
            bus.busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        grant         <= gidx;
                        grant_oh      <= gonehot;
                        cnt           <= '0;
                        bus.mem_ce    <= 1'b1;
                        bus.mem_rw    <= bus.m_rw[gidx];
                        bus.mem_addr  <= bus.m_addr[gidx*ADDR_W +: ADDR_W];
                        bus.mem_wdata <= bus.m_wdata[gidx*DATA_W +: DATA_W];
                        bus.busy      <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    // mem_valid is checked first so it wins a tie with the timeout
                    if (bus.mem_valid) begin
                        bus.m_rdata      <= bus.mem_rdata;
                        bus.m_resp_valid <= grant_oh;
                        bus.mem_ce       <= 1'b0;
                        state            <= RESP;
                    end else begin
                        cnt <= (&cnt) ? cnt : cnt + CW'(1);
                        if (TIMEOUT != 0 && {1'b0, cnt} + (CW + 1)'(1) == TO) begin
                            bus.m_rdata      <= '0;
                            bus.m_resp_valid <= grant_oh;
                            bus.m_resp_err   <= grant_oh;
                            bus.mem_ce       <= 1'b0;
                            state            <= RESP;
                        end
                    end
                end
                default: begin
                    bus.m_resp_valid <= '0;
                    bus.m_resp_err   <= '0;
                    bus.busy         <= 1'b0;
                    rr_ptr           <= (grant == IW'(N_MASTERS - 1)) ? '0 : grant + IW'(1);
                    state            <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: vector table, hand sequences and randomized round-robin model check
module tb_soc_mem_arbiter;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 4;

    typedef struct {
        logic [N-1:0] req;
        int           lat;
        int           g;
        logic         err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int ptr = 0;
    logic [AW-1:0] addr [N];
    logic [DW-1:0] wdat [N];
    logic [N-1:0]  rw;
    vec_t tbl [8];

    always #5 clk = ~clk;

    soc_mem_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) b ();

    soc_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++)
            if (req[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic randomize_payload();
        for (int i = 0; i < N; i++) begin
            addr[i] = $urandom;
            wdat[i] = $urandom;
            rw[i]   = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drive_masters(input logic [N-1:0] req);
        b.m_req = req;
        for (int i = 0; i < N; i++) begin
            b.m_rw[i]              = rw[i];
            b.m_addr[i*AW +: AW]   = addr[i];
            b.m_wdata[i*DW +: DW]  = wdat[i];
        end
    endtask

    // called at a negedge in IDLE; returns at the negedge after the response cycle
    task automatic txn(input logic [N-1:0] req, input int lat, input int g, input logic err,
                       input logic [DW-1:0] rd);
        int waited = 0;
        int ce_cnt = 0;
        drive_masters(req);
        while (!b.mem_ce && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        chk("grant_wait", 64'(b.mem_ce), 64'(1));
        if (!b.mem_ce) begin
            b.m_req = '0;
            return;
        end
        chk("mem_rw", 64'(b.mem_rw), 64'(rw[g]));
        chk("mem_addr", 64'(b.mem_addr), 64'(addr[g]));
        chk("mem_wdata", 64'(b.mem_wdata), 64'(wdat[g]));
        for (int i = 0; i < (err ? T : lat + 1); i++) begin
            ce_cnt += b.mem_ce ? 1 : 0;
            if (!err && i == lat) begin
                b.mem_valid = 1'b1;
                b.mem_rdata = rd;
            end
            @(negedge clk);
            b.mem_valid = 1'b0;
        end
        chk("ce_cycles", 64'(ce_cnt), 64'(err ? T : lat + 1));
        chk("resp_valid", 64'(b.m_resp_valid), 64'(1) << g);
        chk("resp_err", 64'(b.m_resp_err), err ? 64'(1) << g : 64'(0));
        chk("rdata", 64'(b.m_rdata), err ? 64'(0) : 64'(rd));
        chk("ce_drop", 64'(b.mem_ce), 64'(0));
        chk("busy_resp", 64'(b.busy), 64'(1));
        @(negedge clk);
        chk("resp_pulse_end", 64'(b.m_resp_valid), 64'(0));
        chk("busy_idle", 64'(b.busy), 64'(0));
        b.m_req = '0;
        ptr = (g + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int last;
        int n;
        logic [N-1:0] req;
        int lat;
        int g;
        tbl[0] = '{3'b011, 0, 1, 1'b0};
        tbl[1] = '{3'b011, 2, 0, 1'b0};
        tbl[2] = '{3'b100, 4, 2, 1'b1};
        tbl[3] = '{3'b110, 3, 1, 1'b0};
        tbl[4] = '{3'b111, 1, 2, 1'b0};
        tbl[5] = '{3'b001, 6, 0, 1'b1};
        tbl[6] = '{3'b101, 0, 2, 1'b0};
        tbl[7] = '{3'b010, 5, 1, 1'b1};
        b.m_req = '0;
        b.m_rw = '0;
        b.m_addr = '0;
        b.m_wdata = '0;
        b.mem_valid = 1'b0;
        b.mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ce", 64'(b.mem_ce), 64'(0));
        chk("rst_busy", 64'(b.busy), 64'(0));
        chk("rst_resp", 64'({b.m_resp_valid, b.m_resp_err}), 64'(0));
        chk("rst_rdata", 64'(b.m_rdata), 64'(0));
        chk("rst_mem_bus", 64'({b.mem_rw, b.mem_addr}) | 64'(b.mem_wdata), 64'(0));
        b.mem_valid = 1'b1;
        b.mem_rdata = 32'h1234;
        @(negedge clk);
        b.mem_valid = 1'b0;
        chk("idle_valid_busy", 64'(b.busy), 64'(0));
        chk("idle_valid_resp", 64'(b.m_resp_valid), 64'(0));
        // contention: both masters held, slave answers immediately
        addr[0] = 32'h100; addr[1] = 32'h200; addr[2] = 32'h300;
        wdat = '{0, 0, 0};
        rw = '0;
        drive_masters(3'b011);
        b.mem_valid = 1'b1;
        last = -1;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (b.mem_ce) begin
                chk("cont_addr", 64'(b.mem_addr), 64'(addr[n % 2]));
                if (last >= 0) chk("cont_interval", 64'(c - last), 64'(3));
                last = c;
                n++;
            end
        end
        chk("cont_grants", 64'(n), 64'(4));
        b.m_req = '0;
        @(negedge clk);
        b.mem_valid = 1'b0;
        @(negedge clk);
        ptr = 0;
        // single read of 0x40
        randomize_payload();
        addr[0] = 32'h40;
        rw[0] = 1'b0;
        txn(3'b001, 2, 0, 1'b0, 32'hDEAD);
        foreach (tbl[i]) begin
            randomize_payload();
            txn(tbl[i].req, tbl[i].lat, tbl[i].g, tbl[i].err, DW'($urandom));
        end
        // async reset in the middle of an access
        randomize_payload();
        drive_masters(3'b001);
        @(negedge clk);
        chk("pre_rst_ce", 64'(b.mem_ce), 64'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_ce", 64'(b.mem_ce), 64'(0));
        chk("async_rst_busy", 64'(b.busy), 64'(0));
        chk("async_rst_resp", 64'(b.m_resp_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        txn(3'b010, 1, 1, 1'b0, DW'($urandom));
        for (int i = 0; i < 40; i++) begin
            randomize_payload();
            req = N'($urandom_range(1, (1 << N) - 1));
            lat = $urandom_range(0, T + 2);
            g = pick(req, ptr);
            txn(req, lat, g, lat >= T, DW'($urandom));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
